instruction_sequencer: RTL

Upstream of `write_address`: latches the 16-bit instruction word and sequences each instruction through five phases (fetch, read, execute, memory, write-back). It slices the instruction register into the decode fields that `write_address` and the other decode stages consume (`op1`, `Ra_op2`, `Rd_Rb`, `op3`, displacement). It also provides run/halt control, including stopping on the HLT instruction.

---
 rtl/instruction_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Latches the 16-bit instruction word and steps each instruction through five
// phases: fetch, read, execute, memory and write-back. The instruction
// register is split into decode fields for the downstream stages. Run/halt is
// controlled by exec pulses and by the HLT instruction.
//
// Ports
//   clock    in   1   rising-edge clock
//   reset    in   1   asynchronous, active-low reset
//   exec     in   1   run/stop request pulse
//   instr    in  16   instruction word, valid during phase 0
//   op1      out  2   ir[15:14]
//   Ra_op2   out  3   ir[13:11]
//   Rd_Rb    out  3   ir[10:8]
//   op3      out  4   ir[7:4]
//   d8       out  8   ir[7:0], displacement
//   d4       out  4   ir[3:0], shift amount
//   phase    out  3   current phase, 0..4
//   irLoad   out  1   running in phase 0 (IR captures instr at this edge)
//   pcWrite  out  1   running in phase 4 (PC updates at this edge)
//   running  out  1   1 = sequencing, 0 = halted
//   retired  out 16   completed-instruction count, wraps
module instruction_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic [15:0] instr,
  output logic [1:0]  op1,
  output logic [2:0]  Ra_op2,
  output logic [2:0]  Rd_Rb,
  output logic [3:0]  op3,
  output logic [7:0]  d8,
  output logic [3:0]  d4,
  output logic [2:0]  phase,
  output logic        irLoad,
  output logic        pcWrite,
  output logic        running,
  output logic [15:0] retired
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PH_FETCH = PHASE_W'(0);
  localparam logic [PHASE_W-1:0] PH_WB    = PHASE_W'(4);

  typedef enum logic {
    HALTED = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   retired_q, retired_d;
  logic                stop_q, stop_d;
  logic                irload_q, irload_d;
  logic                pcwrite_q, pcwrite_d;
  logic                is_hlt;

  // HLT: op1 = 11 and op3 = 1111, decoded from the held instruction
  assign is_hlt = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'b1111);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HALTED;
      phase_q   <= PH_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      stop_q    <= 1'b0;
      irload_q  <= 1'b0;
      pcwrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      stop_q    <= stop_d;
      irload_q  <= irload_d;
      pcwrite_q <= pcwrite_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    stop_d    = stop_q;
    unique case (state_q)
      HALTED: begin
        // exec while halted is only ever a restart, never a stop request
        phase_d = PH_FETCH;
        stop_d  = 1'b0;
        if (exec) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (phase_q == PH_FETCH) begin
          ir_d = instr;
        end
        if (phase_q == PH_WB) begin
          retired_d = retired_q + DATA_W'(1);
          phase_d   = PH_FETCH;
          // a stop arriving on the write-back edge itself is honoured here
          if (is_hlt || stop_q || exec) begin
            state_d = HALTED;
            stop_d  = 1'b0;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
          if (exec) begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HALTED;
        phase_d = PH_FETCH;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Strobe decode from the upcoming (state, phase) so the strobes are registered
  always_comb begin
    irload_d  = 1'b0;
    pcwrite_d = 1'b0;
    if (state_d == RUN) begin
      irload_d  = (phase_d == PH_FETCH);
      pcwrite_d = (phase_d == PH_WB);
    end
  end

  assign op1     = ir_q[15:14];
  assign Ra_op2  = ir_q[13:11];
  assign Rd_Rb   = ir_q[10:8];
  assign op3     = ir_q[7:4];
  assign d8      = ir_q[7:0];
  assign d4      = ir_q[3:0];
  assign phase   = phase_q;
  assign irLoad  = irload_q;
  assign pcWrite = pcwrite_q;
  assign running = (state_q == RUN);
  assign retired = retired_q;

endmodule
